// File: rtl/student_fir_pkg.sv
`default_nettype none
// ============================================================================
// Package   : student_fir_pkg
// Purpose   : Shared types and sample limits for the FIR core and its
//             output stage.
// Revision  : 1.0  initial release
// ============================================================================
package student_fir_pkg;

  localparam int ACC_WIDTH    = 32;
  localparam int SAMPLE_WIDTH = 16;

  typedef logic signed [ACC_WIDTH-1:0]    acc_t;
  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/student_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module    : student_sync_fifo
// Purpose   : Synchronous first-word-fall-through FIFO with occupancy output.
//             A push on a full FIFO is refused unless a pop happens in the
//             same cycle; refused pushes are reported on o_drop.
// Revision  : 1.0  initial release
// ============================================================================
module student_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_depth = LW'(DEPTH);

  // Occupancy state; the level counter is the source of truth, the state
  // register just caches the empty/full decode for the next cycle.
  localparam logic [1:0] c_EMPTY    = 2'd0;
  localparam logic [1:0] c_NONEMPTY = 2'd1;
  localparam logic [1:0] c_FULL     = 2'd2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [1:0]       r_state;

  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic [LW-1:0]    w_level_nxt;
  logic [1:0]       w_state_nxt;

  assign w_empty   = (r_state == c_EMPTY);
  assign w_full    = (r_state == c_FULL);
  assign w_pop_ok  = i_pop & ~w_empty;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign o_drop    = i_push & w_full & ~w_pop_ok;

  // Next level and the state it implies.
  always_comb begin
    w_level_nxt = r_level + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
    if (w_level_nxt == '0) begin
      w_state_nxt = c_EMPTY;
    end else if (w_level_nxt == c_depth) begin
      w_state_nxt = c_FULL;
    end else begin
      w_state_nxt = c_NONEMPTY;
    end
  end

  // Pointer, level and state update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_state  <= c_EMPTY;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/student_fir_out_stage.sv
`default_nettype none
// ============================================================================
// Module    : student_fir_out_stage
// Purpose   : Captures the FIR accumulator on each strobe rising edge,
//             rounds half-up, shifts and saturates to a sample, buffers it in
//             a FWFT FIFO and presents it over valid/ready. Counts saturated
//             and dropped results.
// Revision  : 1.0  initial release
// ============================================================================
module student_fir_out_stage
  import student_fir_pkg::*;
#(
  parameter int DATA_SIZE_FIR_OUT = ACC_WIDTH,
  parameter int DATA_SIZE         = SAMPLE_WIDTH,
  parameter int SHIFT             = 15,
  parameter int FIFO_DEPTH        = 4,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          valid_strobe_in,
  input  logic [DATA_SIZE_FIR_OUT-1:0]  y_in,
  input  logic                          clear_i,
  output logic [DATA_SIZE-1:0]          sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [CNT_WIDTH-1:0]          sat_count_o,
  output logic [CNT_WIDTH-1:0]          drop_count_o,
  output logic                          overflow_o
);

  localparam int SW = DATA_SIZE_FIR_OUT + 1;

  // Half-LSB rounding constant and the sample range expressed in SW bits.
  localparam logic signed [SW-1:0] c_round = {{(SW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [SW-1:0] c_smax  = {{(SW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] c_smin  = {{(SW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  logic                   r_strobe_prev;
  logic                   r_s1_valid;
  logic signed [SW-1:0]   r_s1_sum;
  logic                   r_s2_valid;
  logic [DATA_SIZE-1:0]   r_s2_data;
  logic                   r_s2_sat;
  logic [CNT_WIDTH-1:0]   r_sat_cnt;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;
  logic                   r_overflow;

  logic                   w_edge;
  logic signed [SW-1:0]   w_shifted;
  logic [DATA_SIZE-1:0]   w_sample;
  logic                   w_sat;
  logic                   w_pop;
  logic                   w_drop;

  assign w_edge    = valid_strobe_in & ~r_strobe_prev;
  assign w_shifted = r_s1_sum >>> SHIFT;

  // Clamp the floor-shifted value into the signed sample range.
  always_comb begin
    w_sat    = 1'b0;
    w_sample = w_shifted[DATA_SIZE-1:0];
    if (w_shifted > c_smax) begin
      w_sat    = 1'b1;
      w_sample = {1'b0, {(DATA_SIZE-1){1'b1}}};
    end else if (w_shifted < c_smin) begin
      w_sat    = 1'b1;
      w_sample = {1'b1, {(DATA_SIZE-1){1'b0}}};
    end
  end

  // Two-stage round / shift-saturate pipeline driven by strobe rising edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_strobe_prev <= 1'b0;
      r_s1_valid    <= 1'b0;
      r_s1_sum      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_data     <= '0;
      r_s2_sat      <= 1'b0;
    end else begin
      r_strobe_prev <= valid_strobe_in;
      r_s1_valid    <= w_edge;
      if (w_edge) r_s1_sum <= $signed({y_in[DATA_SIZE_FIR_OUT-1], y_in}) + c_round;
      r_s2_valid    <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_sample;
        r_s2_sat  <= w_sat;
      end
    end
  end

  assign w_pop = sample_valid_o & sample_ready_i;

  student_sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_push  (r_s2_valid),
    .i_data  (r_s2_data),
    .i_pop   (w_pop),
    .o_data  (sample_o),
    .o_valid (sample_valid_o),
    .o_level (fifo_level_o),
    .o_drop  (w_drop)
  );

  // Saturating status counters and sticky overflow; a clear beats an increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_sat_cnt  <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (r_s2_valid && r_s2_sat && (r_sat_cnt != '1)) r_sat_cnt <= r_sat_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != '1))               r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_drop)                                      r_overflow <= 1'b1;
    end
  end

  assign sat_count_o  = r_sat_cnt;
  assign drop_count_o = r_drop_cnt;
  assign overflow_o   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_student_fir_out_stage.sv
`default_nettype none
// ============================================================================
// Module    : tb_student_fir_out_stage
// Purpose   : Self-checking bench for student_fir_out_stage with a
//             transaction-level reference model and directed scenarios.
// Revision  : 1.0  initial release
// ============================================================================
module tb_student_fir_out_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [31:0] y;
  logic        clear;
  logic [15:0] sample;
  logic        valid;
  logic        ready;
  logic [2:0]  level;
  logic [15:0] sat_cnt;
  logic [15:0] drop_cnt;
  logic        ovf;

  always #5 clk = ~clk;

  student_fir_out_stage #(
    .DATA_SIZE_FIR_OUT (32),
    .DATA_SIZE         (16),
    .SHIFT             (15),
    .FIFO_DEPTH        (4),
    .CNT_WIDTH         (16)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_strobe_in (strobe),
    .y_in            (y),
    .clear_i         (clear),
    .sample_o        (sample),
    .sample_valid_o  (valid),
    .sample_ready_i  (ready),
    .fifo_level_o    (level),
    .sat_count_o     (sat_cnt),
    .drop_count_o    (drop_cnt),
    .overflow_o      (ovf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results travel through a 2-deep delay line, then
  // enter a bounded queue of 4; counters follow the documented rules.
  bit          m_prev, p1v, p2v, chk_en;
  logic [31:0] p1y, p2y;
  logic [15:0] mq[$];
  int          m_sat, m_drop;
  bit          m_ovf;

  function automatic logic [15:0] ref_sample(input logic [31:0] yy, output bit sat);
    longint v;
    v = longint'($signed(yy));
    v = (v + 64'sd16384) >>> 15;
    sat = 1'b0;
    if (v > 32767) begin
      sat = 1'b1;
      return 16'h7FFF;
    end else if (v < -32768) begin
      sat = 1'b1;
      return 16'h8000;
    end
    return v[15:0];
  endfunction

  always @(posedge clk) begin : model
    bit          pop, st_edge, s_sat;
    logic [15:0] s;
    if (rst) begin
      m_prev = 0; p1v = 0; p2v = 0;
      mq.delete();
      m_sat = 0; m_drop = 0; m_ovf = 0;
    end else begin
      pop     = (mq.size() > 0) && ready;
      st_edge = strobe && !m_prev;
      if (pop) void'(mq.pop_front());
      if (p2v) begin
        s = ref_sample(p2y, s_sat);
        if (s_sat && m_sat < 65535) m_sat++;
        if (mq.size() < 4) mq.push_back(s);
        else begin
          if (m_drop < 65535) m_drop++;
          m_ovf = 1;
        end
      end
      if (clear) begin
        m_sat = 0; m_drop = 0; m_ovf = 0;
      end
      p2v = p1v; p2y = p1y;
      p1v = st_edge; p1y = y;
      m_prev = strobe;
    end
    chk_en = 1;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("sample_o", {16'h0, sample}, {16'h0, (mq.size() > 0) ? mq[0] : 16'h0});
      chk("sample_valid_o", {31'h0, valid}, {31'h0, mq.size() > 0});
      chk("fifo_level_o", {29'h0, level}, mq.size());
      chk("sat_count_o", {16'h0, sat_cnt}, m_sat);
      chk("drop_count_o", {16'h0, drop_cnt}, m_drop);
      chk("overflow_o", {31'h0, ovf}, {31'h0, m_ovf});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] yy);
    strobe = 1'b1;
    y      = yy;
    tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic expect_sample(input logic [15:0] exp, input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1;
        chk(name, {16'h0, sample}, {16'h0, exp});
      end
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
    tick();
  endtask

  initial begin : main
    bit v[5];
    bit saw;
    rst = 1; strobe = 0; y = 0; clear = 0; ready = 0;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("reset_level", {29'h0, level}, 0);
    chk("reset_valid", {31'h0, valid}, 0);

    // Latency and basic rounding: 0x4000 rounds up to 1, valid in cycle 3.
    ready  = 1;
    strobe = 1; y = 32'h0000_4000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v[i] = valid;
      if (i == 3) chk("lat_sample", {16'h0, sample}, 32'h0001);
      @(posedge clk); #1;
      strobe = 0;
    end
    chk("lat_c2", {31'h0, v[2]}, 0);
    chk("lat_c3", {31'h0, v[3]}, 1);
    chk("lat_sat", {16'h0, sat_cnt}, 0);

    // Saturation in both directions and the exact minimum.
    send(32'h3FFF_FFFF); expect_sample(16'h7FFF, "sat_pos");
    tick(); chk("sat_cnt1", {16'h0, sat_cnt}, 1);
    send(32'h8000_0000); expect_sample(16'h8000, "sat_neg");
    tick(); chk("sat_cnt2", {16'h0, sat_cnt}, 2);
    send(32'hC000_0000); expect_sample(16'h8000, "exact_min");
    tick(); chk("sat_cnt_min", {16'h0, sat_cnt}, 2);

    // Overflow: five results into a stalled sink, one is dropped.
    ready = 0;
    for (int k = 1; k <= 5; k++) send(32'(k) << 15);
    repeat (3) tick();
    chk("ovf_level", {29'h0, level}, 4);
    chk("ovf_drop", {16'h0, drop_cnt}, 1);
    chk("ovf_flag", {31'h0, ovf}, 1);
    ready = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("drain_order", {16'h0, sample}, k);
    end
    tick();
    ready = 0;
    clear = 1; tick(); clear = 0;
    @(negedge clk);
    chk("clr_sat", {16'h0, sat_cnt}, 0);
    chk("clr_drop", {16'h0, drop_cnt}, 0);
    chk("clr_ovf", {31'h0, ovf}, 0);
    tick();

    // Held strobe gives one result; then full + pop + push keeps level 4.
    strobe = 1; y = 32'(7) << 15;
    repeat (10) tick();
    strobe = 0;
    repeat (4) tick();
    chk("held_level", {29'h0, level}, 1);
    for (int k = 8; k <= 10; k++) send(32'(k) << 15);
    repeat (3) tick();
    chk("full_level", {29'h0, level}, 4);
    strobe = 1; y = 32'(11) << 15;
    tick(); strobe = 0;
    tick(); ready = 1;
    tick(); ready = 0;
    @(negedge clk);
    chk("pp_level", {29'h0, level}, 4);
    chk("pp_drop", {16'h0, drop_cnt}, 0);
    chk("pp_head", {16'h0, sample}, 8);
    ready = 1;
    repeat (6) tick();

    // Randomized traffic; the every-cycle compare does the checking.
    for (int c = 0; c < 600; c++) begin
      strobe = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = 32'($signed($urandom_range(0, 32'h7F_FFFF)) - 32'sh40_0000);
        2: y = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: y = (32'($urandom_range(0, 65535)) << 15) | 32'h4000 | 32'hC000_0000;
      endcase
      ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 49) == 0);
      tick();
    end

    // Reset one cycle after a strobe edge: the result must never appear.
    strobe = 0; clear = 0; ready = 1;
    repeat (8) tick();
    strobe = 1; y = 32'h0000_4000;
    tick();
    strobe = 0; rst = 1;
    tick();
    rst = 0;
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid) saw = 1;
    end
    chk("rst_no_sample", {31'h0, saw}, 0);
    chk("rst_level", {29'h0, level}, 0);
    chk("rst_sample", {16'h0, sample}, 0);
    chk("rst_counts", {drop_cnt, sat_cnt}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
